// File: rtl/quickq_sorted_pq.sv
// quickq_sorted_pq: single-cycle sorted priority queue.
// Entries live in a register array kept in precedence order, so entry 0 is
// always the head. Every slot decides independently, from two neighbouring
// key compares, whether it holds, shifts up, shifts down or takes the new
// entry, so insert, remove-head and replace all complete in one cycle.
// Invalid slots are always kept at zero, which makes head_key/head_data read
// 0 while the queue is empty without any output gating.
module quickq_sorted_pq #(
  parameter int KEY_W     = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int MAX_FIRST = 0,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [KEY_W-1:0]  enq_key,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq_req,
  output logic              head_valid,
  output logic [KEY_W-1:0]  head_key,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  // Per-slot source select.
  localparam logic [1:0] SEL_HOLD = 2'd0;  // keep own contents
  localparam logic [1:0] SEL_UP   = 2'd1;  // take entry i-1 (insert shift)
  localparam logic [1:0] SEL_DOWN = 2'd2;  // take entry i+1 (remove shift)
  localparam logic [1:0] SEL_NEW  = 2'd3;  // take the incoming entry

  logic [KEY_W-1:0]  key_reg   [DEPTH];
  logic [DATA_W-1:0] data_reg  [DEPTH];
  logic [DEPTH-1:0]  valid_reg;

  logic [KEY_W-1:0]  key_next  [DEPTH];
  logic [DATA_W-1:0] data_next [DEPTH];
  logic [DEPTH-1:0]  valid_next;

  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              full_reg;
  logic              empty_reg;
  logic              ovf_reg;
  logic              unf_reg;

  // slot_m[i]: the incoming key belongs at or before slot i, i.e. slot i is
  // empty or the new key strictly precedes key[i]. Because the array is sorted
  // this mask is monotone: all zeros, then all ones. The extra top bit stands
  // for the position just past the array.
  logic [DEPTH:0]    slot_m;

  logic              do_enq;
  logic              do_deq;

  assign enq_ready = !full_reg | deq_req;
  assign do_enq    = enq_valid & enq_ready;
  assign do_deq    = deq_req & !empty_reg;

  assign slot_m[DEPTH] = 1'b1;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic              prec;
      logic              first_ins;
      logic              first_rep;
      logic [1:0]        sel;
      logic [KEY_W-1:0]  key_below;
      logic [DATA_W-1:0] data_below;
      logic              valid_below;
      logic [KEY_W-1:0]  key_above;
      logic [DATA_W-1:0] data_above;
      logic              valid_above;

      // Strict compare: equal keys never precede, so ties stay FIFO.
      if (MAX_FIRST != 0) begin : g_max
        assign prec = enq_key > key_reg[gi];
      end else begin : g_min
        assign prec = enq_key < key_reg[gi];
      end

      assign slot_m[gi] = !valid_reg[gi] | prec;

      // Neighbour taps; the array edges read as empty, zeroed slots.
      if (gi == 0) begin : g_first
        assign key_below   = '0;
        assign data_below  = '0;
        assign valid_below = 1'b0;
        // Insert position in the current array is slot 0.
        assign first_ins   = slot_m[0];
        // Insert position in the array with the head removed is slot 0.
        assign first_rep   = slot_m[1];
      end else begin : g_mid
        assign key_below   = key_reg[gi-1];
        assign data_below  = data_reg[gi-1];
        assign valid_below = valid_reg[gi-1];
        assign first_ins   = slot_m[gi] & !slot_m[gi-1];
        assign first_rep   = slot_m[gi+1] & !slot_m[gi];
      end

      if (gi == DEPTH - 1) begin : g_last
        assign key_above   = '0;
        assign data_above  = '0;
        assign valid_above = 1'b0;
      end else begin : g_low
        assign key_above   = key_reg[gi+1];
        assign data_above  = data_reg[gi+1];
        assign valid_above = valid_reg[gi+1];
      end

      // Choose where this slot's next contents come from.
      always_comb begin
        sel = SEL_HOLD;
        if (do_enq && do_deq) begin
          // Replace: the array shifted down by one, with the new entry
          // inserted into it. Slots below the insert point shift down, the
          // insert point takes the new entry, slots above it stay in place.
          if (!slot_m[gi+1]) begin
            sel = SEL_DOWN;
          end else if (first_rep) begin
            sel = SEL_NEW;
          end else begin
            sel = SEL_HOLD;
          end
        end else if (do_enq) begin
          if (!slot_m[gi]) begin
            sel = SEL_HOLD;
          end else if (first_ins) begin
            sel = SEL_NEW;
          end else begin
            sel = SEL_UP;
          end
        end else if (do_deq) begin
          sel = SEL_DOWN;
        end
      end

      // Four-way slot mux.
      always_comb begin
        key_next[gi]   = key_reg[gi];
        data_next[gi]  = data_reg[gi];
        valid_next[gi] = valid_reg[gi];
        case (sel)
          SEL_UP: begin
            key_next[gi]   = key_below;
            data_next[gi]  = data_below;
            valid_next[gi] = valid_below;
          end
          SEL_DOWN: begin
            key_next[gi]   = key_above;
            data_next[gi]  = data_above;
            valid_next[gi] = valid_above;
          end
          SEL_NEW: begin
            key_next[gi]   = enq_key;
            data_next[gi]  = enq_data;
            valid_next[gi] = 1'b1;
          end
          default: begin
            key_next[gi]   = key_reg[gi];
            data_next[gi]  = data_reg[gi];
            valid_next[gi] = valid_reg[gi];
          end
        endcase
      end
    end
  endgenerate

  // Occupancy update; a replace leaves the count unchanged.
  always_comb begin
    count_next = count_reg;
    if (do_enq && !do_deq) begin
      count_next = count_reg + CNT_W'(1);
    end else if (do_deq && !do_enq) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Register the array, occupancy flags and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_reg[i]  <= '0;
        data_reg[i] <= '0;
      end
      valid_reg <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        key_reg[i]  <= key_next[i];
        data_reg[i] <= data_next[i];
      end
      valid_reg <= valid_next;
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(DEPTH));
      empty_reg <= (count_next == '0);
      ovf_reg   <= enq_valid & full_reg & !deq_req;
      unf_reg   <= deq_req & empty_reg;
    end
  end

  assign head_valid = valid_reg[0];
  assign head_key   = key_reg[0];
  assign head_data  = data_reg[0];
  assign count      = count_reg;
  assign full       = full_reg;
  assign empty      = empty_reg;
  assign ovf        = ovf_reg;
  assign unf        = unf_reg;

endmodule

// File: tb/tb_quickq_sorted_pq.sv
// Directed bench for quickq_sorted_pq: a default min-first instance (a) and a
// max-first, 16-bit, depth-4 instance (b). Expected values are hand-computed.
module tb_quickq_sorted_pq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: KEY_W=32, DATA_W=32, DEPTH=8, MAX_FIRST=0
  logic        a_rst;
  logic        a_enq_valid;
  logic        a_enq_ready;
  logic [31:0] a_enq_key;
  logic [31:0] a_enq_data;
  logic        a_deq_req;
  logic        a_head_valid;
  logic [31:0] a_head_key;
  logic [31:0] a_head_data;
  logic [3:0]  a_count;
  logic        a_full;
  logic        a_empty;
  logic        a_ovf;
  logic        a_unf;

  // Instance b: KEY_W=16, DATA_W=8, DEPTH=4, MAX_FIRST=1
  logic        b_rst;
  logic        b_enq_valid;
  logic        b_enq_ready;
  logic [15:0] b_enq_key;
  logic [7:0]  b_enq_data;
  logic        b_deq_req;
  logic        b_head_valid;
  logic [15:0] b_head_key;
  logic [7:0]  b_head_data;
  logic [2:0]  b_count;
  logic        b_full;
  logic        b_empty;
  logic        b_ovf;
  logic        b_unf;

  int n_cmp = 0;
  int n_err = 0;

  quickq_sorted_pq #(
    .KEY_W(32), .DATA_W(32), .DEPTH(8), .MAX_FIRST(0)
  ) dut_a (
    .clk(clk), .rst(a_rst),
    .enq_valid(a_enq_valid), .enq_ready(a_enq_ready),
    .enq_key(a_enq_key), .enq_data(a_enq_data),
    .deq_req(a_deq_req),
    .head_valid(a_head_valid), .head_key(a_head_key), .head_data(a_head_data),
    .count(a_count), .full(a_full), .empty(a_empty),
    .ovf(a_ovf), .unf(a_unf)
  );

  quickq_sorted_pq #(
    .KEY_W(16), .DATA_W(8), .DEPTH(4), .MAX_FIRST(1)
  ) dut_b (
    .clk(clk), .rst(b_rst),
    .enq_valid(b_enq_valid), .enq_ready(b_enq_ready),
    .enq_key(b_enq_key), .enq_data(b_enq_data),
    .deq_req(b_deq_req),
    .head_valid(b_head_valid), .head_key(b_head_key), .head_data(b_head_data),
    .count(b_count), .full(b_full), .empty(b_empty),
    .ovf(b_ovf), .unf(b_unf)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic op_a(input logic ev, input logic [31:0] k, input logic [31:0] d, input logic dq);
    a_enq_valid = ev;
    a_enq_key   = k;
    a_enq_data  = d;
    a_deq_req   = dq;
    step();
    a_enq_valid = 1'b0;
    a_deq_req   = 1'b0;
    $display("[a] enq=%0b key=%0d data=0x%0h deq=%0b | hv=%0b head=%0d hdata=0x%0h cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
             ev, k, d, dq, a_head_valid, a_head_key, a_head_data, a_count,
             a_full, a_empty, a_ovf, a_unf);
  endtask

  task automatic op_b(input logic r, input logic ev, input logic [15:0] k, input logic [7:0] d, input logic dq);
    b_rst       = r;
    b_enq_valid = ev;
    b_enq_key   = k;
    b_enq_data  = d;
    b_deq_req   = dq;
    step();
    b_rst       = 1'b0;
    b_enq_valid = 1'b0;
    b_deq_req   = 1'b0;
    $display("[b] rst=%0b enq=%0b key=0x%0h deq=%0b | hv=%0b head=0x%0h cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
             r, ev, k, dq, b_head_valid, b_head_key, b_count,
             b_full, b_empty, b_ovf, b_unf);
  endtask

  initial begin
    a_rst = 1'b1; a_enq_valid = 1'b0; a_enq_key = '0; a_enq_data = '0; a_deq_req = 1'b0;
    b_rst = 1'b1; b_enq_valid = 1'b0; b_enq_key = '0; b_enq_data = '0; b_deq_req = 1'b0;

    // ---------------- reset then idle ----------------
    step();
    step();
    a_rst = 1'b0;
    b_rst = 1'b0;
    op_a(1'b0, 32'd0, 32'd0, 1'b0);
    check_val("rst_count",  64'(a_count),      64'd0);
    check_val("rst_empty",  64'(a_empty),      64'd1);
    check_val("rst_full",   64'(a_full),       64'd0);
    check_val("rst_hvalid", 64'(a_head_valid), 64'd0);
    check_val("rst_hkey",   64'(a_head_key),   64'd0);
    check_val("rst_hdata",  64'(a_head_data),  64'd0);
    check_val("rst_ready",  64'(a_enq_ready),  64'd1);
    check_val("rst_ovf",    64'(a_ovf),        64'd0);
    check_val("rst_unf",    64'(a_unf),        64'd0);

    // ---------------- sorting ----------------
    op_a(1'b1, 32'd40, 32'h400, 1'b0);
    check_val("sort_h40", 64'(a_head_key), 64'd40);
    check_val("sort_hv",  64'(a_head_valid), 64'd1);
    op_a(1'b1, 32'd10, 32'h100, 1'b0);
    check_val("sort_h10a", 64'(a_head_key), 64'd10);
    op_a(1'b1, 32'd30, 32'h300, 1'b0);
    check_val("sort_h10b", 64'(a_head_key), 64'd10);
    op_a(1'b1, 32'd20, 32'h200, 1'b0);
    check_val("sort_h10c", 64'(a_head_key), 64'd10);
    check_val("sort_hd10", 64'(a_head_data), 64'h100);
    check_val("sort_cnt4", 64'(a_count), 64'd4);
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("drain_h20", 64'(a_head_key), 64'd20);
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("drain_h30", 64'(a_head_key), 64'd30);
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("drain_h40", 64'(a_head_key), 64'd40);
    check_val("drain_hd40", 64'(a_head_data), 64'h400);
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("drain_empty", 64'(a_empty), 64'd1);
    check_val("drain_hv0",   64'(a_head_valid), 64'd0);
    check_val("drain_hkey0", 64'(a_head_key), 64'd0);
    check_val("drain_hdat0", 64'(a_head_data), 64'd0);

    // ---------------- stable ties ----------------
    op_a(1'b1, 32'd5, 32'hA, 1'b0);
    op_a(1'b1, 32'd5, 32'hB, 1'b0);
    op_a(1'b1, 32'd3, 32'hC, 1'b0);
    check_val("tie_first_C", 64'(a_head_data), 64'hC);
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("tie_second_A", 64'(a_head_data), 64'hA);
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("tie_third_B", 64'(a_head_data), 64'hB);
    check_val("tie_key5", 64'(a_head_key), 64'd5);
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("tie_empty", 64'(a_empty), 64'd1);

    // ---------------- full / overflow / replace ----------------
    for (int i = 1; i <= 8; i++) begin
      op_a(1'b1, 32'(i), 32'(i * 16), 1'b0);
    end
    check_val("full_flag", 64'(a_full), 64'd1);
    check_val("full_cnt",  64'(a_count), 64'd8);
    a_enq_valid = 1'b1; a_enq_key = 32'd9; a_enq_data = 32'h90; a_deq_req = 1'b0;
    #1;
    check_val("full_ready0", 64'(a_enq_ready), 64'd0);
    op_a(1'b1, 32'd9, 32'h90, 1'b0);
    check_val("ovf_pulse", 64'(a_ovf), 64'd1);
    check_val("ovf_cnt",   64'(a_count), 64'd8);
    check_val("ovf_head",  64'(a_head_key), 64'd1);
    op_a(1'b0, 32'd0, 32'd0, 1'b0);
    check_val("ovf_clear", 64'(a_ovf), 64'd0);
    a_enq_valid = 1'b1; a_enq_key = 32'd0; a_enq_data = 32'hEE; a_deq_req = 1'b1;
    #1;
    check_val("repl_ready1", 64'(a_enq_ready), 64'd1);
    op_a(1'b1, 32'd0, 32'hEE, 1'b1);
    check_val("repl_head0", 64'(a_head_key), 64'd0);
    check_val("repl_hdata", 64'(a_head_data), 64'hEE);
    check_val("repl_cnt8",  64'(a_count), 64'd8);
    check_val("repl_full",  64'(a_full), 64'd1);
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("repl_key1_gone", 64'(a_head_key), 64'd2);
    for (int k = 3; k <= 8; k++) begin
      op_a(1'b0, 32'd0, 32'd0, 1'b1);
      check_val("repl_drain_key",  64'(a_head_key), 64'(k));
      check_val("repl_drain_data", 64'(a_head_data), 64'(k * 16));
      check_val("repl_drain_cnt",  64'(a_count), 64'(9 - k));
    end
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("repl_drain_empty", 64'(a_empty), 64'd1);

    // ---------------- underflow ----------------
    op_a(1'b0, 32'd0, 32'd0, 1'b1);
    check_val("unf_pulse", 64'(a_unf), 64'd1);
    check_val("unf_cnt0",  64'(a_count), 64'd0);
    check_val("unf_empty", 64'(a_empty), 64'd1);
    op_a(1'b1, 32'd7, 32'h77, 1'b1);
    check_val("unf_enq_pulse", 64'(a_unf), 64'd1);
    check_val("unf_enq_cnt1",  64'(a_count), 64'd1);
    check_val("unf_enq_head7", 64'(a_head_key), 64'd7);
    op_a(1'b0, 32'd0, 32'd0, 1'b0);
    check_val("unf_clear", 64'(a_unf), 64'd0);

    // ---------------- max-first, depth 4 ----------------
    op_b(1'b0, 1'b1, 16'h0001, 8'h11, 1'b0);
    check_val("b_head_0001", 64'(b_head_key), 64'h0001);
    op_b(1'b0, 1'b1, 16'hFFFF, 8'h22, 1'b0);
    check_val("b_head_ffff", 64'(b_head_key), 64'hFFFF);
    op_b(1'b0, 1'b1, 16'h8000, 8'h33, 1'b0);
    check_val("b_head_ffff2", 64'(b_head_key), 64'hFFFF);
    check_val("b_hdata",      64'(b_head_data), 64'h22);
    check_val("b_cnt3",       64'(b_count), 64'd3);
    op_b(1'b0, 1'b1, 16'h9000, 8'h44, 1'b1);
    check_val("b_repl_head", 64'(b_head_key), 64'h9000);
    check_val("b_repl_cnt",  64'(b_count), 64'd3);
    op_b(1'b0, 1'b1, 16'h0002, 8'h55, 1'b0);
    check_val("b_full", 64'(b_full), 64'd1);
    op_b(1'b1, 1'b1, 16'h1234, 8'h66, 1'b1);
    check_val("b_rst_cnt",   64'(b_count), 64'd0);
    check_val("b_rst_empty", 64'(b_empty), 64'd1);
    check_val("b_rst_hv",    64'(b_head_valid), 64'd0);
    check_val("b_rst_hkey",  64'(b_head_key), 64'd0);
    op_b(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    check_val("b_post_cnt",   64'(b_count), 64'd0);
    check_val("b_post_full",  64'(b_full), 64'd0);
    check_val("b_post_hkey",  64'(b_head_key), 64'd0);
    check_val("b_post_hdata", 64'(b_head_data), 64'd0);
    check_val("b_post_ready", 64'(b_enq_ready), 64'd1);
    check_val("b_post_ovf",   64'(b_ovf), 64'd0);
    check_val("b_post_unf",   64'(b_unf), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
